// File: rtl/data_pipe_pkg.sv
// Shared types and helpers for the data pipe interconnect family:
// skid-pipe state encoding, beat layout template and path decode.
package data_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam int PIPE_DEFAULT_DSIZE = 8;

    // Reference beat layout; instances declare the same shape at their own data width.
    typedef struct packed {
        logic [PIPE_DEFAULT_DSIZE-1:0] data;
        logic                          last;
    } pipe_beat_t;

    // One bit of the one-hot decode of a path index.
    function automatic logic path_decode_bit(input int unsigned path, input int unsigned channel);
        return path == channel;
    endfunction

endpackage

// File: rtl/data_pipe_skid2.sv
// Two-entry skid pipe (connector + overflow buffer) with plain valid/ready
// on both sides; in_ready is decoded from the state register only.
module data_pipe_skid2
    import data_pipe_pkg::*;
#(
    parameter type beat_t = pipe_beat_t
) (
    input  logic  clock,
    input  logic  rst,
    input  logic  clk_en,
    input  logic  in_valid,
    input  beat_t in_beat,
    output logic  in_ready,
    output logic  out_valid,
    output beat_t out_beat,
    input  logic  out_ready,
    output logic  empty
);

    pipe_state_t state;
    pipe_state_t state_next;
    beat_t       connector;
    beat_t       buffer;
    logic        acc_in;
    logic        acc_out;
    logic        load_conn_in;
    logic        load_conn_buf;
    logic        load_buf;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign empty     = (state == EMPTY);
    assign out_beat  = connector;
    assign acc_in    = in_valid & in_ready & clk_en;
    assign acc_out   = out_valid & out_ready & clk_en;

    always_comb begin
        state_next    = state;
        load_conn_in  = 1'b0;
        load_conn_buf = 1'b0;
        load_buf      = 1'b0;
        case (state)
            EMPTY: begin
                if (acc_in) begin
                    state_next   = ONE;
                    load_conn_in = 1'b1;
                end
            end
            ONE: begin
                if (acc_in && !acc_out) begin
                    state_next = TWO;
                    load_buf   = 1'b1;
                end else if (!acc_in && acc_out) begin
                    state_next = EMPTY;
                end else if (acc_in && acc_out) begin
                    load_conn_in = 1'b1;
                end
            end
            TWO: begin
                if (acc_out) begin
                    state_next    = ONE;
                    load_conn_buf = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            connector <= '0;
            buffer    <= '0;
        end else begin
            if (load_conn_in) begin
                connector <= in_beat;
            end else if (load_conn_buf) begin
                connector <= buffer;
            end
            if (load_buf) begin
                buffer <= in_beat;
            end
        end
    end

endmodule

// File: rtl/data_pipe_interconnect_1ton.sv
// 1-to-NUM stream demux through a 2-entry skid pipe; path switches are queued
// and applied only once the pipe drains. Optional macro: PIPE_PKT_LOCK_EN.
module data_pipe_interconnect_1ton
    import data_pipe_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int NUM   = 8,
    parameter int PW    = $clog2(NUM)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             vld_sw,
    input  logic [PW-1:0]    sw,
    output logic [PW-1:0]    curr_path,
    output logic             curr_path_vld,
    output logic             sw_err,
    input  logic             s_valid,
    input  logic [DSIZE-1:0] s_data,
`ifdef PIPE_PKT_LOCK_EN
    input  logic             s_last,
    output logic             m_last,
`endif
    output logic             s_ready,
    output logic [NUM-1:0]   m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic [NUM-1:0]   m_ready
);

`ifdef PIPE_PKT_LOCK_EN
    typedef struct packed {
        logic [DSIZE-1:0] data;
        logic             last;
    } beat_t;
`else
    typedef struct packed {
        logic [DSIZE-1:0] data;
    } beat_t;
`endif

    localparam logic [PW:0] NUM_LIMIT = (PW+1)'(NUM);

    logic           pend_vld;
    logic [PW-1:0]  pend_path;
    logic           sw_ok;
    logic           apply;
    logic           apply_ok;
    logic           intake_ok;
    logic           pipe_in_ready;
    logic           pipe_out_valid;
    logic           pipe_out_ready;
    logic           pipe_empty;
    logic [NUM-1:0] path_sel;
    beat_t          in_beat;
    beat_t          out_beat;

    assign sw_ok = ({1'b0, sw} < NUM_LIMIT);

`ifdef PIPE_PKT_LOCK_EN
    logic in_pkt;

    assign in_beat   = '{data: s_data, last: s_last};
    assign m_last    = out_beat.last;
    assign apply_ok  = !in_pkt;
    // An open packet keeps intake alive so it finishes on the old path.
    assign intake_ok = !pend_vld | in_pkt;

    always_ff @(posedge clock) begin
        if (rst) begin
            in_pkt <= 1'b0;
        end else if (s_valid && s_ready && clk_en) begin
            in_pkt <= !s_last;
        end
    end
`else
    assign in_beat   = '{data: s_data};
    assign apply_ok  = 1'b1;
    assign intake_ok = !pend_vld;
`endif

    assign s_ready = curr_path_vld & intake_ok & pipe_in_ready;
    assign apply   = pipe_empty & pend_vld & clk_en & apply_ok;

    always_ff @(posedge clock) begin
        if (rst) begin
            curr_path     <= '0;
            curr_path_vld <= 1'b0;
            pend_path     <= '0;
            pend_vld      <= 1'b0;
            sw_err        <= 1'b0;
        end else if (clk_en) begin
            sw_err <= vld_sw & !sw_ok;
            if (apply) begin
                curr_path     <= pend_path;
                curr_path_vld <= 1'b1;
                pend_vld      <= 1'b0;
            end
            // A request landing with an apply becomes the next pending one.
            if (vld_sw && sw_ok) begin
                pend_path <= sw;
                pend_vld  <= 1'b1;
            end
        end
    end

    always_comb begin
        path_sel = '0;
        for (int unsigned ch = 0; ch < NUM; ch++) begin
            path_sel[ch] = path_decode_bit(32'(curr_path), ch);
        end
    end

    assign m_valid        = pipe_out_valid ? path_sel : '0;
    assign pipe_out_ready = |(path_sel & m_ready);
    assign m_data         = out_beat.data;

    data_pipe_skid2 #(
        .beat_t (beat_t)
    ) u_skid (
        .clock     (clock),
        .rst       (rst),
        .clk_en    (clk_en),
        .in_valid  (s_valid & curr_path_vld & intake_ok),
        .in_beat   (in_beat),
        .in_ready  (pipe_in_ready),
        .out_valid (pipe_out_valid),
        .out_beat  (out_beat),
        .out_ready (pipe_out_ready),
        .empty     (pipe_empty)
    );

endmodule
